muldiv_unit: RTL and testbench

- Iterative RV64M multiply/divide execute stage that sits directly downstream of the register file.
- Consumes the two source operands read from the register file, computes over multiple cycles, and produces a write-back triple (ptr_wr, data_wr, wr_en) that feeds the register file's write port.
- Issue side uses a start/busy handshake; the result is presented for exactly one cycle.

---
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Issue/write-back bundle between the register file read side and the multiply/divide unit.
// Master (issuer): start, op, rs1_data, rs2_data, rd_ptr. Slave (unit): busy, done, wr_en, ptr_wr, data_wr.
// Pure wiring: no latency or storage inside the interface itself.
interface muldiv_unit_if #(
    parameter int N    = 32,
    parameter int Bits = 64
);
    localparam int PW = $clog2(N);

    logic            start;
    logic [2:0]      op;
    logic [Bits-1:0] rs1_data;
    logic [Bits-1:0] rs2_data;
    logic [PW-1:0]   rd_ptr;
    logic            busy;
    logic            done;
    logic            wr_en;
    logic [PW-1:0]   ptr_wr;
    logic [Bits-1:0] data_wr;

    modport master (
        output start, op, rs1_data, rs2_data, rd_ptr,
        input  busy, done, wr_en, ptr_wr, data_wr
    );

    modport slave (
        input  start, op, rs1_data, rs2_data, rd_ptr,
        output busy, done, wr_en, ptr_wr, data_wr
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide stage producing a register-file write-back (ptr_wr, data_wr, wr_en).
// Latency: Bits+2 cycles start-to-done; divide-by-zero and signed overflow finish in 1 cycle.
// Backpressure: start is ignored while busy=1 (no queueing); done/wr_en pulse for one cycle.
// Ports: clk, rst (async, active-high); bus (slave modport of muldiv_unit_if).
module muldiv_unit #(
    parameter int N    = 32,
    parameter int Bits = 64
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   bus
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(Bits);
    localparam logic [Bits-1:0] MIN_NEG = {1'b1, {(Bits-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q;
    logic [2:0]      op_q;
    logic [PW-1:0]   ptr_q;
    logic            neg_a_q, neg_b_q;
    logic [Bits-1:0] hi_q, lo_q, mag_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q, wr_en_q;
    logic [Bits-1:0] data_q;

    // Operand decode at acceptance: magnitudes, sign flags and the two short-circuit cases.
    logic            sgn_a, sgn_b, a_neg, b_neg, div0, ovf;
    logic [Bits-1:0] abs_a, abs_b, spec_res;

    always_comb begin
        sgn_a    = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
        sgn_b    = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
        a_neg    = sgn_a & bus.rs1_data[Bits-1];
        b_neg    = sgn_b & bus.rs2_data[Bits-1];
        abs_a    = a_neg ? -bus.rs1_data : bus.rs1_data;
        abs_b    = b_neg ? -bus.rs2_data : bus.rs2_data;
        div0     = bus.op[2] && (bus.rs2_data == '0);
        ovf      = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
                   (bus.rs1_data == MIN_NEG) && (bus.rs2_data == '1);
        // op[1] distinguishes REM/REMU from DIV/DIVU.
        if (div0) spec_res = bus.op[1] ? bus.rs1_data : '1;
        else      spec_res = bus.op[1] ? '0 : bus.rs1_data;
    end

    // One iteration. Multiply: {hi,lo} holds partial product with the multiplier shifting
    // out of lo. Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    logic [Bits:0]   mul_sum, div_sh, div_diff;
    logic [Bits-1:0] hi_d, lo_d;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        div_sh   = {hi_q, lo_q[Bits-1]};
        div_diff = div_sh - {1'b0, mag_q};
        if (op_q[2]) begin
            // Borrow out of the top bit means the trial subtraction failed: restore.
            if (!div_diff[Bits]) begin
                hi_d = div_diff[Bits-1:0];
                lo_d = {lo_q[Bits-2:0], 1'b1};
            end else begin
                hi_d = div_sh[Bits-1:0];
                lo_d = {lo_q[Bits-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[Bits:1];
            lo_d = {mul_sum[0], lo_q[Bits-1:1]};
        end
    end

    // Sign fix-up and result select, consumed in the FIX state.
    logic [2*Bits-1:0] prod, prod_s;
    logic [Bits-1:0]   quo_s, rem_s, fix_res;

    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo_s  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
        rem_s  = neg_a_q ? -hi_q : hi_q;
        case (op_q)
            3'd0:             fix_res = prod_s[Bits-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod_s[2*Bits-1:Bits];
            3'd4, 3'd5:       fix_res = quo_s;
            default:          fix_res = rem_s;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            ptr_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        ptr_q   <= bus.rd_ptr;
                        neg_a_q <= a_neg;
                        neg_b_q <= b_neg;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        hi_q    <= '0;
                        if (div0 || ovf) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            wr_en_q <= (bus.rd_ptr != '0);
                            data_q  <= spec_res;
                        end else begin
                            state_q <= CALC;
                            lo_q    <= bus.op[2] ? abs_a : abs_b;
                            mag_q   <= bus.op[2] ? abs_b : abs_a;
                        end
                    end
                end
                CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(Bits-1)) state_q <= FIX;
                end
                FIX: begin
                    data_q  <= fix_res;
                    done_q  <= 1'b1;
                    wr_en_q <= (ptr_q != '0);
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.ptr_wr  = ptr_q;
    assign bus.data_wr = data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam int BITS = 64;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;

    muldiv_unit_if #(.N(32), .Bits(BITS)) bus ();
    muldiv_unit #(.N(32), .Bits(BITS)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain wide arithmetic on the RISC-V M-extension rules.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        logic signed [127:0] sa, sb;
        logic [127:0] ua, ub, p;
        longint la, lb, q;
        sa = $signed(a);
        sb = $signed(b);
        ua = {64'd0, a};
        ub = {64'd0, b};
        la = a;
        lb = b;
        p  = '0;
        q  = 0;
        case (op)
            3'd0: begin p = ua * ub; return p[63:0]; end
            3'd1: begin p = sa * sb; return p[127:64]; end
            3'd2: begin p = sa * ub; return p[127:64]; end
            3'd3: begin p = ua * ub; return p[127:64]; end
            3'd4: begin
                if (b == 0) return ONES;
                if (a == MIN && b == ONES) return MIN;
                q = la / lb;
                return q;
            end
            3'd5: return (b == 0) ? ONES : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == ONES) return 64'd0;
                q = la % lb;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == MIN && b == ONES) return 1;
        return BITS + 2;
    endfunction

    // Issue one op and follow it to done. Cycle 1 is the first cycle after the accepting edge.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input int glitch_at,
                          output logic [63:0] data, output int lat, output int busy_cnt,
                          output logic wr, output logic [4:0] ptr, output logic tail_ok);
        data = '0; lat = -1; busy_cnt = 0; wr = 1'b0; ptr = '0; tail_ok = 1'b0;
        @(negedge clk);
        bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_ptr = rd; bus.start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (c == glitch_at) begin
                bus.start = 1'b1; bus.op = 3'd7;
                bus.rs1_data = 64'd999; bus.rs2_data = 64'd5; bus.rd_ptr = 5'd7;
            end else if (c == glitch_at + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                lat = c; data = bus.data_wr; wr = bus.wr_en; ptr = bus.ptr_wr;
                bus.start = 1'b0;
                break;
            end
        end
        @(negedge clk);
        tail_ok = !bus.busy && !bus.done && !bus.wr_en && (bus.data_wr == data);
    endtask

    task automatic wait_done(output int cycles, output logic [63:0] data);
        cycles = -1; data = '0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (bus.done) begin cycles = c; data = bus.data_wr; break; end
        end
    endtask

    vec_t        vt[12];
    logic [63:0] r_data, ra, rb, d1, d2;
    int          r_lat, r_busy, c1, c2;
    logic        r_wr, r_tail, quiet;
    logic [4:0]  r_ptr, rd;
    logic [2:0]  rop;

    function automatic logic [63:0] pick(input int sel);
        case (sel)
            0: return 64'd0;
            1: return ONES;
            2: return MIN;
            3: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        vt[0]  = '{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
        vt[1]  = '{3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        vt[2]  = '{3'd1, ONES, ONES, 64'd0, 66};
        vt[3]  = '{3'd2, ONES, 64'd2, ONES, 66};
        vt[4]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        vt[5]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66};
        vt[6]  = '{3'd5, 64'd100, 64'd7, 64'd14, 66};
        vt[7]  = '{3'd7, 64'd100, 64'd7, 64'd2, 66};
        vt[8]  = '{3'd5, 64'd42, 64'd0, ONES, 1};
        vt[9]  = '{3'd6, 64'd42, 64'd0, 64'd42, 1};
        vt[10] = '{3'd4, MIN, ONES, MIN, 1};
        vt[11] = '{3'd6, MIN, ONES, 64'd0, 1};

        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_ptr = '0;
        #1;
        check("reset_busy",    64'(bus.busy),    64'd0);
        check("reset_done",    64'(bus.done),    64'd0);
        check("reset_wr_en",   64'(bus.wr_en),   64'd0);
        check("reset_ptr_wr",  64'(bus.ptr_wr),  64'd0);
        check("reset_data_wr", bus.data_wr,      64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            rd = 5'(i + 5);
            run_op(vt[i].op, vt[i].a, vt[i].b, rd, 0, r_data, r_lat, r_busy, r_wr, r_ptr, r_tail);
            check($sformatf("vec%0d_data", i), r_data, vt[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(r_lat), 64'(vt[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 64'(r_busy), 64'(vt[i].lat));
            check($sformatf("vec%0d_ptr_wr", i), 64'(r_ptr), 64'(rd));
            check($sformatf("vec%0d_wr_en", i), 64'(r_wr), 64'd1);
            check($sformatf("vec%0d_tail", i), 64'(r_tail), 64'd1);
        end

        // rd=0 suppresses the write; a start pulse mid-operation is ignored.
        run_op(3'd0, 64'd3, 64'd4, 5'd0, 10, r_data, r_lat, r_busy, r_wr, r_ptr, r_tail);
        check("rd0_data",    r_data,       64'd12);
        check("rd0_latency", 64'(r_lat),   64'd66);
        check("rd0_wr_en",   64'(r_wr),    64'd0);
        check("rd0_ptr_wr",  64'(r_ptr),   64'd0);
        check("rd0_tail",    64'(r_tail),  64'd1);

        // Reset in the middle of a divide.
        @(negedge clk);
        bus.op = 3'd4; bus.rs1_data = 64'h1234_5678_9ABC_DEF0; bus.rs2_data = 64'h1234;
        bus.rd_ptr = 5'd9; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy",    64'(bus.busy),   64'd0);
        check("abort_done",    64'(bus.done),   64'd0);
        check("abort_wr_en",   64'(bus.wr_en),  64'd0);
        check("abort_data_wr", bus.data_wr,     64'd0);
        check("abort_ptr_wr",  64'(bus.ptr_wr), 64'd0);
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy || bus.done || bus.wr_en) quiet = 1'b0;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy || bus.done || bus.wr_en) quiet = 1'b0;
        end
        check("abort_quiet", 64'(quiet), 64'd1);
        run_op(3'd0, 64'd2, 64'd2, 5'd3, 0, r_data, r_lat, r_busy, r_wr, r_ptr, r_tail);
        check("post_reset_data",    r_data,     64'd4);
        check("post_reset_latency", 64'(r_lat), 64'd66);
        check("post_reset_wr_en",   64'(r_wr),  64'd1);

        // Back-to-back issue with start held high.
        @(negedge clk);
        bus.op = 3'd0; bus.rs1_data = 64'd5; bus.rs2_data = 64'd6; bus.rd_ptr = 5'd1;
        bus.start = 1'b1;
        wait_done(c1, d1);
        wait_done(c2, d2);
        bus.start = 1'b0;
        check("b2b_first_latency", 64'(c1), 64'd66);
        check("b2b_first_data",    d1,      64'd30);
        check("b2b_gap",           64'(c2), 64'd67);
        check("b2b_second_data",   d2,      64'd30);
        @(negedge clk);

        // Randomized ops against the reference model.
        for (int k = 0; k < 30; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick($urandom_range(0, 7));
            rb  = pick($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 31));
            run_op(rop, ra, rb, rd, 0, r_data, r_lat, r_busy, r_wr, r_ptr, r_tail);
            check($sformatf("rand%0d_op%0d_data", k, rop), r_data, ref_result(rop, ra, rb));
            check($sformatf("rand%0d_latency", k), 64'(r_lat), 64'(exp_lat(rop, ra, rb)));
            check($sformatf("rand%0d_wr_en", k), 64'(r_wr), 64'(rd != 0));
            check($sformatf("rand%0d_ptr_wr", k), 64'(r_ptr), 64'(rd));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
